// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multicycle processor control unit.
//
// Holds the FSM state enumeration (4-bit encoding), the supported opcode
// constants, and the encodings driven on the alu_op, alu_src_b and pc_source
// selects. No ports; imported by the interface, the controller and the bench.
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_REX    = 4'd6,
        ST_RWB    = 4'd7,
        ST_IEX    = 4'd8,
        ST_IWB    = 4'd9,
        ST_BEQ    = 4'd10,
        ST_JMP    = 4'd11,
        ST_ILL    = 4'd12
    } state_t;

    // Instruction bits 31-26.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select: register B, constant 4, sign-extended immediate,
    // immediate shifted left by two (branch offset).
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PC source select: live ALU result, ALU result register, jump target.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if -- bundle between the control unit and its datapath.
//
//   opcode        IR bits 31-26                 (datapath -> control)
//   mem_ready     memory access completes       (datapath -> control)
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_source[1:0]                 (control -> datapath)
//   illegal       one-cycle unsupported-opcode pulse
//   state[3:0]    current FSM state (debug)
//   instret       retired-instruction count, CNT_W bits
//
// master = control unit, slave = datapath.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state, instret
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state, instret
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl -- control FSM for a multicycle MIPS-style datapath.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master: opcode/mem_ready in, datapath
//          controls, illegal pulse, debug state and instret out
//
// All controls are Moore decodes of the state register except pc_write and
// ir_write in FETCH, which wait on mem_ready so the PC and IR load only on
// the cycle the instruction word actually arrives.
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    // Next-state decode. MEMADR re-reads the opcode; it comes from the
    // instruction register, which is stable for the whole instruction.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_FETCH:  if (bus.mem_ready) w_next_state = ST_DECODE;
            ST_DECODE: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_RTYPE:     w_next_state = ST_REX;
                    OP_ADDI:      w_next_state = ST_IEX;
                    OP_BEQ:       w_next_state = ST_BEQ;
                    OP_J:         w_next_state = ST_JMP;
                    default:      w_next_state = ST_ILL;
                endcase
            end
            ST_MEMADR: w_next_state = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (bus.mem_ready) w_next_state = ST_MEMWB;
            ST_MEMWR:  if (bus.mem_ready) w_next_state = ST_FETCH;
            ST_REX:    w_next_state = ST_RWB;
            ST_IEX:    w_next_state = ST_IWB;
            ST_MEMWB, ST_RWB, ST_IWB, ST_BEQ, ST_JMP, ST_ILL:
                       w_next_state = ST_FETCH;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state. MEMWR
    // is the only final state that can stall, so it needs mem_ready too.
    always_comb begin
        w_retire = 1'b0;
        unique case (r_state)
            ST_MEMWB, ST_RWB, ST_IWB, ST_BEQ, ST_JMP: w_retire = 1'b1;
            ST_MEMWR:                                 w_retire = bus.mem_ready;
            default:                                  w_retire = 1'b0;
        endcase
    end

    // Reset drops any in-flight access on the floor: the FSM restarts at
    // FETCH, so a write strobe cut off by reset is never re-issued.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Output decode.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.illegal       = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_write  = bus.mem_ready;
                bus.ir_write  = bus.mem_ready;
            end
            ST_DECODE: bus.alu_src_b = SRCB_BOFF;
            ST_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            ST_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            ST_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            ST_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            ST_IEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            ST_IWB: bus.reg_write = 1'b1;
            ST_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            ST_JMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            ST_ILL:  bus.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.state   = r_state;
    assign bus.instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl -- self-checking bench for multicycle_ctrl.
//
// Two controllers run in lockstep on the same stimulus: one with the default
// 32-bit instret and one with a 4-bit instret to exercise wraparound. For
// each instruction the bench builds the expected state walk from the opcode
// and a chosen number of memory stall cycles, then checks every cycle's
// state and control word against a table of per-state controls, and checks
// the retired count after each instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus32 ();
    multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

    multicycle_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus32));
    multicycle_ctrl #(.CNT_W(4))  dut_4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    typedef struct {
        state_t st;
        logic   rdy;
    } step_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_instret = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word required in each state, written straight from the
    // state table; rdy only matters in FETCH.
    function automatic ctl_t exp_ctl(input state_t st, input logic rdy);
        ctl_t c = '0;
        case (st)
            ST_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy; end
            ST_DECODE: c.alu_src_b = 2'b11;
            ST_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
            ST_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
            ST_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            ST_REX:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            ST_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
            ST_IEX:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_IWB:    c.reg_write = 1;
            ST_BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            ST_JMP:    begin c.pc_write = 1; c.pc_source = 2'b10; end
            ST_ILL:    c.illegal = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t sample32();
        ctl_t c;
        c.pc_write      = bus32.pc_write;
        c.pc_write_cond = bus32.pc_write_cond;
        c.iord          = bus32.iord;
        c.mem_read      = bus32.mem_read;
        c.mem_write     = bus32.mem_write;
        c.ir_write      = bus32.ir_write;
        c.reg_dst       = bus32.reg_dst;
        c.mem_to_reg    = bus32.mem_to_reg;
        c.reg_write     = bus32.reg_write;
        c.alu_src_a     = bus32.alu_src_a;
        c.alu_src_b     = bus32.alu_src_b;
        c.alu_op        = bus32.alu_op;
        c.pc_source     = bus32.pc_source;
        c.illegal       = bus32.illegal;
        return c;
    endfunction

    task automatic drive(input logic [5:0] opc, input logic rdy);
        bus32.opcode    = opc;
        bus4.opcode     = opc;
        bus32.mem_ready = rdy;
        bus4.mem_ready  = rdy;
    endtask

    // Run one instruction. sf = stall cycles in FETCH, sm = stall cycles in
    // MEMRD/MEMWR. abort_at >= 0 asserts reset mid-cycle at that step.
    task automatic run_instr(input logic [5:0] opc, input int sf, input int sm, input int abort_at);
        step_t q[$];
        logic  retires = 1'b1;
        for (int i = 0; i < sf; i++) q.push_back('{ST_FETCH, 1'b0});
        q.push_back('{ST_FETCH, 1'b1});
        q.push_back('{ST_DECODE, 1'($urandom_range(0, 1))});
        case (opc)
            OP_LW: begin
                q.push_back('{ST_MEMADR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < sm; i++) q.push_back('{ST_MEMRD, 1'b0});
                q.push_back('{ST_MEMRD, 1'b1});
                q.push_back('{ST_MEMWB, 1'($urandom_range(0, 1))});
            end
            OP_SW: begin
                q.push_back('{ST_MEMADR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < sm; i++) q.push_back('{ST_MEMWR, 1'b0});
                q.push_back('{ST_MEMWR, 1'b1});
            end
            OP_RTYPE: begin
                q.push_back('{ST_REX, 1'($urandom_range(0, 1))});
                q.push_back('{ST_RWB, 1'($urandom_range(0, 1))});
            end
            OP_ADDI: begin
                q.push_back('{ST_IEX, 1'($urandom_range(0, 1))});
                q.push_back('{ST_IWB, 1'($urandom_range(0, 1))});
            end
            OP_BEQ:  q.push_back('{ST_BEQ, 1'($urandom_range(0, 1))});
            OP_J:    q.push_back('{ST_JMP, 1'($urandom_range(0, 1))});
            default: begin
                q.push_back('{ST_ILL, 1'($urandom_range(0, 1))});
                retires = 1'b0;
            end
        endcase

        foreach (q[i]) begin
            @(negedge clk);
            drive(opc, q[i].rdy);
            #1;
            check("state",  64'(bus32.state), 64'(q[i].st));
            check("state4", 64'(bus4.state),  64'(q[i].st));
            check("ctl",    64'(sample32()),  64'(exp_ctl(q[i].st, q[i].rdy)));
            check("rd_wr_excl", 64'(bus32.mem_read & bus32.mem_write), 64'(0));
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_state",   64'(bus32.state),     64'(ST_FETCH));
                check("rst_memwr",   64'(bus32.mem_write), 64'(0));
                check("rst_instret", 64'(bus32.instret),   64'(0));
                check("rst_instret4", 64'(bus4.instret),   64'(0));
                check("rst_illegal", 64'(bus32.illegal),   64'(0));
                m_instret = '0;
                @(negedge clk);
                drive(opc, 1'b0);
                rst_n = 1'b1;
                return;
            end
        end

        if (retires) m_instret++;
        // One FETCH stall cycle after each instruction to check the count.
        @(negedge clk);
        drive(opc, 1'b0);
        #1;
        check("instret",  64'(bus32.instret), 64'(m_instret));
        check("instret4", 64'(bus4.instret),  64'(m_instret[3:0]));
        check("idle_state", 64'(bus32.state), 64'(ST_FETCH));
        check("idle_ctl", 64'(sample32()), 64'(exp_ctl(ST_FETCH, 1'b0)));
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] opc;
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        drive(6'b000000, 1'b0);
        #12;
        check("reset_state",    64'(bus32.state),   64'(ST_FETCH));
        check("reset_instret",  64'(bus32.instret), 64'(0));
        check("reset_instret4", 64'(bus4.instret),  64'(0));
        check("reset_illegal",  64'(bus32.illegal), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: R-type, lw with 3 read stalls, beq then j, illegal.
        run_instr(OP_RTYPE, 0, 0, -1);
        run_instr(OP_LW,    0, 3, -1);
        run_instr(OP_BEQ,   0, 0, -1);
        run_instr(OP_J,     0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);

        // 16 addi: the 4-bit counter passes 15 and wraps to 0.
        for (int i = 0; i < 16; i++) run_instr(OP_ADDI, 0, 0, -1);

        // Reset while a store is stalled in MEMWR (step 4 = second MEMWR cycle).
        run_instr(OP_SW, 0, 3, 4);
        run_instr(OP_RTYPE, 0, 0, -1);

        // Random instruction mix with random memory stalls.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) opc = 6'($urandom);
            else                           opc = legal_ops[$urandom_range(0, 5)];
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        // Reset mid-store after random traffic, then recover.
        run_instr(OP_SW, 1, 2, 4);
        run_instr(OP_LW, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction bits 31-26 from the instruction register.
REQ-005 mem_ready  input  1  shared memory has completed the current access this cycle.
REQ-006 pc_write, pc_write_cond  output  1 each  unconditional PC load; PC load qualified by ALU zero.
REQ-007 iord  output  1  memory address source: 0 = PC, 1 = ALU result register.
REQ-008 mem_read, mem_write, ir_write  output  1 each  memory strobes; instruction register load.
REQ-009 reg_dst, mem_to_reg, reg_write  output  1 each  register-file write controls.
REQ-010 alu_src_a  output  1; alu_src_b  output  2; alu_op  output  2; pc_source  output  2  datapath mux and ALU selects.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 state  output  4  current FSM state, for debug.
REQ-013 instret  output  CNT_W  count of retired instructions.

Function
REQ-014 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; all others are illegal.
REQ-015 The FSM SHALL have these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP, ILL.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- While mem_ready=0: stay in FETCH; pc_write=0, ir_write=0.
- When mem_ready=1: pc_write=1, ir_write=1, go to DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
- Next state: lw/sw -> MEMADR; R -> REX; addi -> IEX; beq -> BEQ; j -> JMP; other -> ILL.
REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-020 MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then go to FETCH and count the instruction as retired.
REQ-021 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH; retire.
REQ-022 REX: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB.
REQ-023 RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH; retire.
REQ-024 IEX: alu_src_a=1, alu_src_b=10, alu_op=00; next IWB.
REQ-025 IWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH; retire.
REQ-026 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH; retire.
REQ-027 JMP: pc_write=1, pc_source=10; next FETCH; retire.
REQ-028 ILL: illegal=1 for exactly one cycle; all strobes 0; next FETCH; not retired.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-031 pc_write and ir_write depend on mem_ready only in FETCH; all other outputs are pure decodes of state.
REQ-032 instret SHALL increment by 1 on the clock edge that leaves a retiring state, and wrap modulo 2^CNT_W.
REQ-033 Instruction latencies with mem_ready tied to 1:
- lw: 5 cycles.
- sw, R-type, addi: 4 cycles.
- beq, j: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-034 rst_n=0 SHALL immediately force state=FETCH, instret=0 and illegal=0, including in the middle of an instruction.
REQ-035 After rst_n deasserts, the first rising edge SHALL evaluate FETCH.
REQ-036 A write strobe cut off by reset SHALL NOT be re-issued.

Structure
REQ-037 A shared package mc_pkg SHALL hold:
- the state enumeration (4-bit encoding);
- the opcode constants;
- the alu_op, alu_src_b and pc_source encodings.
REQ-038 The block SHALL be a single module with no sub-module; the next-state and output decodes are separate combinational processes.

Verification
REQ-039 R-type sequence with mem_ready=1: states FETCH, DECODE, REX, RWB, FETCH; reg_write=1, reg_dst=1 only in RWB; instret 0 -> 1.
REQ-040 lw with mem_ready=0 for 3 cycles in MEMRD: 8 cycles total; mem_read and iord held for 4 cycles; one MEMWB write.
REQ-041 beq then j: pc_write_cond pulses in BEQ with pc_source=01, then pc_write in JMP with pc_source=10; instret += 2.
REQ-042 opcode 111111: illegal pulses one cycle; FSM returns to FETCH; instret unchanged.
REQ-043 rst_n asserted mid-MEMWR: state goes to FETCH asynchronously, mem_write drops to 0, instret=0.
REQ-044 CNT_W=4 with 16 addi instructions: instret wraps from 15 to 0.
